// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-entry front end and the hint comparator.
package guess_pkg;

  localparam int BCD_MAX    = 9;
  localparam int NUM_DIGITS = 3;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    EDIT     = 2'd0,
    FIRE     = 2'd1,
    WAIT_REL = 2'd2
  } entry_state_t;

  function automatic digit_t bcd_inc(input digit_t d);
    return (d >= digit_t'(BCD_MAX)) ? digit_t'(0) : d + digit_t'(1);
  endfunction

endpackage

// File: rtl/guess_entry_btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce (GUESS_ENTRY_DEBOUNCE_EN),
// and a registered rising-edge press pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0] sync_q;
  logic       clean;
  logic       prev_q;
  logic       press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

`ifdef GUESS_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          clean_q;

  // Counter runs only while the synchronized input disagrees with the clean level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else if (sync_q[1] != clean_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        clean_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign clean = clean_q;
`else
  assign clean = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= clean;
      press_q <= clean & ~prev_q;
    end
  end

  assign level = clean;
  assign press = press_q;

endmodule

// File: rtl/guess_entry.sv
// Three-digit BCD guess entry with cursor and submit pulse; optional debounce via
// macro GUESS_ENTRY_DEBOUNCE_EN.
module guess_entry
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         restart,
  input  logic         btn_inc,
  input  logic         btn_next,
  input  logic         btn_confirm,
  input  logic [1:0]   Max_digit,
  output digit_t       key0,
  output digit_t       key1,
  output digit_t       key2,
  output logic [1:0]   cursor,
  output logic         confirmButton,
  output entry_state_t state_dbg
);

  logic inc_press, next_press, conf_press;
  logic inc_level, next_level, conf_level;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_inc (
    .clk(clk), .rst_n(restart), .raw(btn_inc), .level(inc_level), .press(inc_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_next (
    .clk(clk), .rst_n(restart), .raw(btn_next), .level(next_level), .press(next_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_conf (
    .clk(clk), .rst_n(restart), .raw(btn_confirm), .level(conf_level), .press(conf_press)
  );

  entry_state_t state_q, state_d;
  digit_t       key_q [NUM_DIGITS];
  digit_t       key_d [NUM_DIGITS];
  logic [1:0]   cursor_q, cursor_d;
  logic         confirm_q;

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state_q   <= EDIT;
      cursor_q  <= 2'd0;
      confirm_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) key_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      confirm_q <= (state_d == FIRE);
      for (int i = 0; i < NUM_DIGITS; i++) key_q[i] <= key_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    for (int i = 0; i < NUM_DIGITS; i++) key_d[i] = key_q[i];

    if (Max_digit == 2'd0) begin
      state_d = EDIT;
    end else begin
      unique case (state_q)
        EDIT: begin
          // One event per cycle: confirm beats next beats inc.
          if (conf_press) begin
            state_d = FIRE;
          end else if (next_press) begin
            cursor_d = (cursor_q == Max_digit - 2'd1) ? 2'd0 : cursor_q + 2'd1;
          end else if (inc_press) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (int'(cursor_q) == i) key_d[i] = bcd_inc(key_q[i]);
            end
          end
        end
        FIRE:     state_d = WAIT_REL;
        WAIT_REL: if (!conf_level) state_d = EDIT;
        default:  state_d = EDIT;
      endcase
    end

    // Digits and cursor outside the active width are cleared regardless of events.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(Max_digit)) key_d[i] = '0;
    end
    if (cursor_d >= Max_digit) cursor_d = 2'd0;
  end

  // Levels of inc/next are only needed for their press pulses.
  logic unused_levels;
  assign unused_levels = inc_level ^ next_level;

  assign key0          = key_q[0];
  assign key1          = key_q[1];
  assign key2          = key_q[2];
  assign cursor        = cursor_q;
  assign confirmButton = confirm_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed button sequences, submit pulses checked by a scoreboard.
module tb_guess_entry;
  import guess_pkg::*;

  localparam int W = 14;
`ifdef GUESS_ENTRY_DEBOUNCE_EN
  localparam int HOLD = 8;
  localparam int IDLE = 14;
`else
  localparam int HOLD = 2;
  localparam int IDLE = 6;
`endif

  logic         clk = 1'b0;
  logic         restart;
  logic         btn_inc, btn_next, btn_confirm;
  logic [1:0]   Max_digit;
  digit_t       key0, key1, key2;
  logic [1:0]   cursor;
  logic         confirmButton;
  entry_state_t state_dbg;

  int asserts = 0;
  int fails   = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_cb = 1'b0;

  guess_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .restart(restart), .btn_inc(btn_inc), .btn_next(btn_next),
    .btn_confirm(btn_confirm), .Max_digit(Max_digit), .key0(key0), .key1(key1),
    .key2(key2), .cursor(cursor), .confirmButton(confirmButton), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_inc = v;
      1: btn_next = v;
      default: btn_confirm = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    repeat (HOLD) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (IDLE) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic [3:0] k2, input logic [3:0] k1,
                              input logic [3:0] k0, input logic [1:0] cur);
    exp_q.push_back({k2, k1, k0, cur});
  endtask

  // scoreboard monitor: each pulse pops one expected snapshot
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (restart === 1'b1 && confirmButton === 1'b1) begin
      asserts++;
      if (prev_cb) begin
        fails++;
        $display("FAIL pulse_width: confirmButton high on consecutive cycles, expected 1 cycle");
      end
      asserts++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got pulse with keys %0h%0h%0h cursor %0d, expected none",
                 key2, key1, key0, cursor);
      end else begin
        e = exp_q.pop_front();
        if ({key2, key1, key0, cursor} !== e) begin
          fails++;
          $display("FAIL pulse_snapshot: got %0h expected %0h", {key2, key1, key0, cursor}, e);
        end
      end
    end
    prev_cb = (restart === 1'b1) && (confirmButton === 1'b1);
  end

  initial begin
    int  n;
    bit  found;
    restart = 1'b0; btn_inc = 1'b0; btn_next = 1'b0; btn_confirm = 1'b0;
    Max_digit = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_key0", 16'(key0), 16'd0);
    check("rst_key1", 16'(key1), 16'd0);
    check("rst_key2", 16'(key2), 16'd0);
    check("rst_cursor", 16'(cursor), 16'd0);
    check("rst_confirm", 16'(confirmButton), 16'd0);
    check("rst_state", 16'(state_dbg), 16'(EDIT));
    restart = 1'b1;
    @(negedge clk);

    // ten increments on a single digit: 1..9 then 0
    for (int i = 1; i <= 10; i++) begin
      press(0);
      check("inc_wrap_key0", 16'(key0), 16'(i % 10));
    end
    check("inc_wrap_cursor", 16'(cursor), 16'd0);

    // next, inc, inc, next, inc on three digits
    Max_digit = 2'd3;
    @(negedge clk);
    press(1); press(0); press(0); press(1); press(0);
    check("seq_key1", 16'(key1), 16'd2);
    check("seq_key2", 16'(key2), 16'd1);
    check("seq_cursor", 16'(cursor), 16'd2);
    press(1);
    check("seq_cursor_wrap", 16'(cursor), 16'd0);

    // confirm held long with inc presses during the hold
    expect_pulse(4'd1, 4'd2, 4'd0, 2'd0);
    btn_confirm = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      btn_inc = 1'b1;
      repeat (HOLD) @(negedge clk);
      btn_inc = 1'b0;
      repeat (HOLD + 2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    btn_confirm = 1'b0;
    repeat (IDLE + 4) @(negedge clk);
    check("hold_pulse_seen", 16'(exp_q.size()), 16'd0);
    check("hold_key0", 16'(key0), 16'd0);
    check("hold_key1", 16'(key1), 16'd2);
    check("hold_key2", 16'(key2), 16'd1);
    check("hold_state", 16'(state_dbg), 16'(EDIT));

    // confirm and inc in the same cycle: confirm wins
    press(1);
    expect_pulse(4'd1, 4'd2, 4'd0, 2'd1);
    btn_confirm = 1'b1; btn_inc = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_confirm = 1'b0; btn_inc = 1'b0;
    repeat (IDLE + 4) @(negedge clk);
    check("coinc_pulse_seen", 16'(exp_q.size()), 16'd0);
    check("coinc_key1", 16'(key1), 16'd2);

`ifndef GUESS_ENTRY_DEBOUNCE_EN
    // raw edge at clock edge k -> pulse in the cycle after edge k+3
    expect_pulse(4'd1, 4'd2, 4'd0, 2'd1);
    btn_confirm = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (confirmButton) break;
    end
    check("confirm_latency", 16'(n), 16'd4);
    btn_confirm = 1'b0;
    repeat (IDLE + 2) @(negedge clk);
    check("latency_pulse_seen", 16'(exp_q.size()), 16'd0);
`endif

    // shrink active width with cursor=2, key2=5
    press(1);
    repeat (4) press(0);
    check("pre_shrink_key2", 16'(key2), 16'd5);
    check("pre_shrink_cursor", 16'(cursor), 16'd2);
    Max_digit = 2'd1;
    @(posedge clk);
    #1;
    check("shrink_cursor", 16'(cursor), 16'd0);
    check("shrink_key2", 16'(key2), 16'd0);
    check("shrink_key1", 16'(key1), 16'd0);

    // reset asserted while in FIRE truncates the pulse
    @(negedge clk);
    Max_digit = 2'd3;
    btn_confirm = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (confirmButton) begin
        found = 1'b1;
        break;
      end
    end
    check("fire_reached", 16'(found), 16'd1);
    check("fire_state", 16'(state_dbg), 16'(FIRE));
    restart = 1'b0;
    #1;
    check("fire_reset_pulse", 16'(confirmButton), 16'd0);
    check("fire_reset_state", 16'(state_dbg), 16'(EDIT));

    // inc held through reset release counts as a fresh press
    btn_confirm = 1'b0;
    btn_inc = 1'b1;
    repeat (2) @(negedge clk);
    restart = 1'b1;
    repeat (HOLD + 2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (IDLE) @(negedge clk);
    check("held_reset_key0", 16'(key0), 16'd1);

    // zero active digits: everything ignored
    Max_digit = 2'd0;
    repeat (2) @(negedge clk);
    check("zero_key0_forced", 16'(key0), 16'd0);
    press(2); press(0); press(1);
    check("zero_key0", 16'(key0), 16'd0);
    check("zero_cursor", 16'(cursor), 16'd0);
    check("zero_state", 16'(state_dbg), 16'(EDIT));

`ifdef GUESS_ENTRY_DEBOUNCE_EN
    // 3-cycle glitch filtered, 6-cycle press accepted
    Max_digit = 2'd1;
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (IDLE) @(negedge clk);
    check("glitch_key0", 16'(key0), 16'd0);
    btn_inc = 1'b1;
    repeat (6) @(negedge clk);
    btn_inc = 1'b0;
    repeat (IDLE) @(negedge clk);
    check("debounced_key0", 16'(key0), 16'd1);
`endif

    repeat (4) @(negedge clk);
    check("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the consecutive stable cycles a synchronized button needs before its clean level updates (minimum 1).
REQ-002 SHALL have port clk  in  1  single system clock; all flops on its rising edge.
REQ-003 SHALL have port restart  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port btn_inc  in  1  raw active-high pushbutton that increments the digit under the cursor.
REQ-005 SHALL have port btn_next  in  1  raw active-high pushbutton that advances the cursor.
REQ-006 SHALL have port btn_confirm  in  1  raw active-high pushbutton that submits the guess.
REQ-007 SHALL have port Max_digit  in  2  count of active digits; valid values are 1..3.
REQ-008 SHALL have ports key0, key1, key2  out  4 each  BCD guess digits; key0 is least significant.
REQ-009 SHALL have port cursor  out  2  index of the digit being edited.
REQ-010 SHALL have port confirmButton  out  1  registered single-cycle submit pulse to the hint comparator.

Function
REQ-011 SHALL condition each button with a 2-flop synchronizer, then a debounce stage (see Configuration), then rising-edge detection on the clean level; each rising edge is one press event.
REQ-012 SHALL implement FSM states EDIT, FIRE and WAIT_REL.
REQ-013 In EDIT, SHALL use priority confirm > next > inc when press events coincide in one cycle; lower-priority events in that cycle are discarded.
REQ-014 In EDIT, an inc event SHALL add 1 to key[cursor], wrapping 9 to 0; values above 9 are unreachable.
REQ-015 In EDIT, a next event SHALL set cursor to cursor+1, or to 0 when cursor == Max_digit-1.
REQ-016 In EDIT, a confirm event SHALL move the FSM to FIRE; confirmButton SHALL be 1 for exactly the one cycle the FSM is in FIRE.
REQ-017 FIRE SHALL always move to WAIT_REL on the next cycle.
REQ-018 In WAIT_REL, all press events SHALL be ignored; the FSM SHALL return to EDIT in the first cycle the clean confirm level is 0.
REQ-019 Digits SHALL keep their values across a confirm; a confirm does not clear entry.
REQ-020 Keys with index >= Max_digit SHALL be forced to 0 on the next cycle, and a cursor >= Max_digit SHALL be forced to 0 on the next cycle.
REQ-021 When Max_digit == 0, all events SHALL be ignored, the FSM SHALL be held in EDIT, and no pulse SHALL be emitted.
REQ-022 Without DEBOUNCE_EN, a raw confirm rising edge sampled at clock edge k SHALL produce confirmButton high in the cycle after edge k+3.

Reset
REQ-023 On restart low, SHALL asynchronously set key0/key1/key2=0, cursor=0, confirmButton=0, FSM=EDIT, synchronizers, clean levels and debounce counters=0.
REQ-024 Reset asserted during FIRE SHALL truncate the pulse immediately.
REQ-025 A button held through reset release SHALL be treated as a new press once debounced.

Configuration
REQ-026 With macro GUESS_ENTRY_DEBOUNCE_EN defined, a clean level SHALL update only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce back SHALL reset the counter to 0.
REQ-027 Without GUESS_ENTRY_DEBOUNCE_EN, the clean level SHALL equal the synchronized input, and no counter logic SHALL be synthesized.

Structure
REQ-028 Package guess_pkg SHALL hold typedef digit_t (4-bit BCD), typedef entry_state_t (EDIT/FIRE/WAIT_REL), constant BCD_MAX=9 and constant NUM_DIGITS=3; the hint comparator shares digit_t.
REQ-029 Sub-module btn_conditioner (sync, optional debounce, rise-edge output) SHALL be instantiated three times.

Verification
REQ-030 With Max_digit=1 and no debounce, 10 inc presses SHALL take key0 through 1..9 and then to 0; cursor SHALL stay 0.
REQ-031 With Max_digit=3, the sequence next, inc, inc, next, inc SHALL give key1=2, key2=1, cursor=2; one further next SHALL give cursor=0.
REQ-032 With confirm held for 20 cycles, confirmButton SHALL be high for exactly 1 cycle, and inc presses during the hold SHALL leave the keys unchanged.
REQ-033 With confirm and inc rising in the same cycle, there SHALL be one pulse and key[cursor] SHALL be unchanged.
REQ-034 With DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle glitch SHALL cause no change, and a 6-cycle press SHALL cause one increment.
REQ-035 With Max_digit changed from 3 to 1 while cursor=2 and key2=5, the next cycle SHALL show cursor=0, key2=0 and key1=0; restart low during FIRE SHALL force confirmButton=0 at once.
